pll_lock_reset_seq: RTL and testbench



---
 rtl/pll_lock_reset_seq_pkg.sv | 22 ++
 rtl/pll_lock_reset_seq_sync.sv | 29 ++
 rtl/pll_lock_reset_seq.sv | 201 ++++++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared definitions for the PLL lock reset sequencer: state encoding,
// relock counter width, PLL reset pulse length and a small width helper.
`timescale 1ns/1ps
package pll_lock_reset_seq_pkg;

    // State encoding is visible on the debug port, so the values are fixed.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        RUN       = 2'd2,
        LOST      = 2'd3
    } state_e;

    localparam int RELOCK_W      = 8;
    localparam int PLL_RST_PULSE = 16;

    // Larger of two integers, used to size shared counters.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync.sv
// Two-flop synchronizer for asynchronous level inputs. Asynchronous
// active-high reset clears both stages to 0.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Reset sequencer downstream of the board PLL. Filters the asynchronous
// PLL lock flag and releases rst_out only after lock has been stable for
// STABLE_CYCLES; re-asserts it for at least HOLD_CYCLES on a sustained
// loss of lock. Optional macro LOCK_TIMEOUT_EN adds a PLL reset pulse
// after LOCK_TIMEOUT cycles spent waiting for lock.
`timescale 1ns/1ps
module pll_lock_reset_seq
    import pll_lock_reset_seq_pkg::*;
#(
    parameter int STABLE_CYCLES = 65536,
    parameter int HOLD_CYCLES   = 256,
    parameter int LOSS_FILTER   = 4,
    parameter int LOCK_TIMEOUT  = 2500000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                locked,
    output logic                rst_out,
    output logic                ready,
    output logic [1:0]          state,
    output logic [RELOCK_W-1:0] relock_count,
    output logic                pll_rst
);

    // One counter serves both STABILIZE and LOST; they are never active together.
    localparam int CNT_W  = max2(1, $clog2(max2(STABLE_CYCLES, HOLD_CYCLES)));
    localparam int LCNT_W = max2(1, $clog2(LOSS_FILTER));

    // Reject parameter values the counters cannot honour.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("STABLE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 1");
    end
    if (LOSS_FILTER < 1) begin : g_bad_loss
        $error("LOSS_FILTER must be >= 1");
    end
    if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
        $error("LOCK_TIMEOUT must be >= 1");
    end

    logic                locked_s;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                rst_out_q, rst_out_d;
    logic                ready_q, ready_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i (clock),
        .rst_i (reset),
        .d_i   (locked),
        .q_o   (locked_s)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lcnt_d   = '0;
        relock_d = relock_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABILIZE;
                end
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    if (lcnt_q == LCNT_W'(LOSS_FILTER - 1)) begin
                        state_d = LOST;
                        if (relock_q != '1) begin
                            relock_d = relock_q + 1'b1;
                        end
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
            end
            LOST: begin
                // Lock state is ignored here: the hold time is unconditional.
                if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they move on the same edge as state.
    always_comb begin
        rst_out_d = (state_d != RUN);
        ready_d   = (state_d == RUN);
    end

    // Counter and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            lcnt_q    <= '0;
            relock_q  <= '0;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            relock_q  <= relock_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
        end
    end

    assign rst_out      = rst_out_q;
    assign ready        = ready_q;
    assign state        = state_q;
    assign relock_count = relock_q;

`ifdef LOCK_TIMEOUT_EN
    localparam int TO_W    = max2(1, $clog2(LOCK_TIMEOUT));
    localparam int PULSE_W = max2(1, $clog2(PLL_RST_PULSE));

    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic               pll_rst_q, pll_rst_d;

    // Timeout counter runs only in WAIT_LOCK; a started pulse always runs to completion.
    always_comb begin
        to_cnt_d    = to_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        pll_rst_d   = pll_rst_q;
        if (pll_rst_q) begin
            to_cnt_d = '0;
            if (pulse_cnt_q == '0) begin
                pll_rst_d = 1'b0;
            end else begin
                pulse_cnt_d = pulse_cnt_q - 1'b1;
            end
        end else if (state_q == WAIT_LOCK) begin
            if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                pll_rst_d   = 1'b1;
                pulse_cnt_d = PULSE_W'(PLL_RST_PULSE - 1);
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Timeout and pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt_q    <= '0;
            pulse_cnt_q <= '0;
            pll_rst_q   <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            pll_rst_q   <= pll_rst_d;
        end
    end

    assign pll_rst = pll_rst_q;
`else
    assign pll_rst = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: run-length behavioural model checked every
// cycle, plus directed scenarios with literal expectations at fixed edges.
`timescale 1ns/1ps
module tb_pll_lock_reset_seq;

    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int LOSS   = 3;
    localparam int TMO    = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       locked;
    logic       rst_out;
    logic       ready;
    logic [1:0] state;
    logic [7:0] relock_count;
    logic       pll_rst;

    pll_lock_reset_seq #(
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .LOSS_FILTER   (LOSS),
        .LOCK_TIMEOUT  (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .locked       (locked),
        .rst_out      (rst_out),
        .ready        (ready),
        .state        (state),
        .relock_count (relock_count),
        .pll_rst      (pll_rst)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Edge count since reset release, raw-lock history, and run lengths.
    int edge_cnt   = 0;
    int m_state    = 0;   // 0 wait, 1 stabilize, 2 run, 3 lost
    int hi_len     = 0;   // consecutive synced-high cycles seen before RUN
    int lo_len     = 0;   // consecutive synced-low cycles seen in RUN
    int hold_cnt   = 0;
    int m_relock   = 0;
    int wl         = 0;   // cycles spent waiting since timeout armed
    int pulse_left = 0;
    logic r1 = 1'b0, r2 = 1'b0;

    task automatic model_step();
        logic ls;
        if (reset) begin
            edge_cnt = 0; m_state = 0; hi_len = 0; lo_len = 0; hold_cnt = 0;
            m_relock = 0; wl = 0; pulse_left = 0; r1 = 1'b0; r2 = 1'b0;
            return;
        end
        edge_cnt++;
        ls = r2; r2 = r1; r1 = locked;
        // PLL reset pulse: 16 cycles after TMO consecutive waiting cycles.
        if (pulse_left > 0) begin
            pulse_left--; wl = 0;
        end else if (m_state == 0) begin
            wl++;
            if (wl == TMO) begin pulse_left = 16; wl = 0; end
        end else begin
            wl = 0;
        end
        case (m_state)
            0, 1: begin
                hi_len = ls ? hi_len + 1 : 0;
                if (hi_len == 0) m_state = 0;
                else if (hi_len <= STABLE) m_state = 1;
                else begin m_state = 2; lo_len = 0; end
            end
            2: begin
                lo_len = ls ? 0 : lo_len + 1;
                if (lo_len == LOSS) begin
                    m_state = 3; hold_cnt = 0;
                    if (m_relock < 255) m_relock++;
                end
            end
            default: begin
                hold_cnt++;
                if (hold_cnt == HOLD) begin m_state = 0; hi_len = 0; end
            end
        endcase
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clock);
        check("cyc_state", state, m_state);
        check("cyc_rst_out", rst_out, (m_state != 2));
        check("cyc_ready", ready, (m_state == 2));
        check("cyc_relock", relock_count, m_relock);
`ifdef LOCK_TIMEOUT_EN
        check("cyc_pll_rst", pll_rst, (pulse_left > 0));
`else
        check("cyc_pll_rst", pll_rst, 1'b0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic goto_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        locked = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        int e;
        reset  = 1'b0;
        locked = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_rst_out", rst_out, 1);
        check("rst_ready", ready, 0);
        check("rst_state", state, 0);
        check("rst_relock", relock_count, 0);
        check("rst_pll_rst", pll_rst, 0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;

        // Lock rises before edge 10: STABILIZE at 12, RUN at 20.
        goto_edge(9);  locked = 1'b1;
        goto_edge(11); check("s1_state_e11", state, 0);
        goto_edge(12); check("s1_state_e12", state, 1); check("s1_rst_e12", rst_out, 1);
        goto_edge(19); check("s1_rst_e19", rst_out, 1); check("s1_ready_e19", ready, 0);
        goto_edge(20); check("s1_rst_e20", rst_out, 0); check("s1_ready_e20", ready, 1);
        check("s1_state_e20", state, 2); check("s1_model_e20", m_state, 2);

        // Two-cycle dropout in RUN is filtered out.
        goto_edge(30); locked = 1'b0;
        goto_edge(32); locked = 1'b1;
        goto_edge(40); check("s3_rst_e40", rst_out, 0); check("s3_relock_e40", relock_count, 0);
        // Sustained loss from edge 100: reset at 104.
        goto_edge(99); locked = 1'b0;
        goto_edge(103); check("s3_rst_e103", rst_out, 0);
        goto_edge(104); check("s3_rst_e104", rst_out, 1); check("s3_state_e104", state, 3);
        check("s3_relock_e104", relock_count, 1); check("s3_model_e104", m_state, 3);

        // Lock back immediately: LOST 104..107, WAIT 108, STABILIZE 109..116, RUN 117.
        locked = 1'b1;
        goto_edge(107); check("s4_state_e107", state, 3);
        goto_edge(108); check("s4_state_e108", state, 0); check("s4_rst_e108", rst_out, 1);
        goto_edge(109); check("s4_state_e109", state, 1);
        goto_edge(116); check("s4_rst_e116", rst_out, 1);
        goto_edge(117); check("s4_rst_e117", rst_out, 0); check("s4_state_e117", state, 2);

        // Repeated losses saturate the relock counter.
        for (int i = 0; i < 256; i++) begin
            e = edge_cnt;
            locked = 1'b0;
            goto_edge(e + 5);
            check("s4_loop_rst", rst_out, 1);
            locked = 1'b1;
            goto_edge(e + 18);
            check("s4_loop_run", state, 2);
        end
        check("s4_relock_sat", relock_count, 255);
        check("s4_model_sat", m_relock, 255);

        // Asynchronous reset in RUN, between clock edges.
        goto_edge(edge_cnt + 5);
        #2 reset = 1'b1;
        #1;
        check("s5_rst_async", rst_out, 1);
        check("s5_ready_async", ready, 0);
        check("s5_state_async", state, 0);
        check("s5_relock_async", relock_count, 0);
        locked = 1'b0;
        @(posedge clock);
        #2 reset = 1'b0;

        // Dropout during STABILIZE restarts the count: STAB 12, WAIT 17, STAB 19, RUN 27.
        goto_edge(9);  locked = 1'b1;
        goto_edge(14); locked = 1'b0;
        goto_edge(16); locked = 1'b1;
        check("s2_state_e16", state, 1);
        goto_edge(17); check("s2_state_e17", state, 0); check("s2_rst_e17", rst_out, 1);
        goto_edge(19); check("s2_state_e19", state, 1);
        goto_edge(26); check("s2_rst_e26", rst_out, 1);
        goto_edge(27); check("s2_rst_e27", rst_out, 0); check("s2_state_e27", state, 2);

`ifdef LOCK_TIMEOUT_EN
        // Timeout pulses while waiting; a pulse in progress completes after lock.
        do_reset();
        goto_edge(19); check("s6_pll_e19", pll_rst, 0);
        goto_edge(20); check("s6_pll_e20", pll_rst, 1);
        goto_edge(35); check("s6_pll_e35", pll_rst, 1);
        goto_edge(36); check("s6_pll_e36", pll_rst, 0);
        goto_edge(55); check("s6_pll_e55", pll_rst, 0);
        goto_edge(56); check("s6_pll_e56", pll_rst, 1);
        goto_edge(58); locked = 1'b1;
        goto_edge(71); check("s6_pll_e71", pll_rst, 1);
        goto_edge(72); check("s6_pll_e72", pll_rst, 0);
        goto_edge(100); check("s6_pll_e100", pll_rst, 0); check("s6_state_e100", state, 2);
`else
        do_reset();
        goto_edge(60); check("s6_pll_off", pll_rst, 0); check("s6_state_wait", state, 0);
`endif

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
